// File: rtl/prescale_timer_ctrl.sv
// -----------------------------------------------------------------------------
// prescale_timer_ctrl
//
// Prescaled down-counting timer. A free-running prescaler divides clk by M
// while the timer runs; every M-th cycle produces a tick, and each tick
// consumes one unit of the latched period. At the end of a timer cycle a
// one-cycle done pulse is issued; one-shot runs then return to idle, while
// periodic runs reload the period and keep going without a gap.
//
// Parameters
//   M : prescaler modulus (clk cycles per tick), M >= 2
//   W : width of period / count
//   N : prescaler register width
//
// Ports
//   i_clk    : clock, rising-edge active
//   i_rstb   : asynchronous active-low reset
//   i_start  : launch request (only honoured in idle)
//   i_stop   : abort request (wins over start and over a final tick)
//   i_mode   : 0 = one-shot, 1 = periodic, latched with start
//   i_period : ticks per timer cycle, latched with start (0 is rejected)
//   o_busy   : high while running
//   o_tick   : combinational prescaled tick
//   o_count  : remaining ticks in the current timer cycle
//   o_done   : registered one-cycle pulse at the end of each timer cycle
//   o_err    : registered one-cycle pulse on a rejected (period = 0) start
// -----------------------------------------------------------------------------
module prescale_timer_ctrl #(
  parameter int M = 10,
  parameter int W = 8,
  parameter int N = $clog2(M)
) (
  input  logic         i_clk,
  input  logic         i_rstb,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_mode,
  input  logic [W-1:0] i_period,
  output logic         o_busy,
  output logic         o_tick,
  output logic [W-1:0] o_count,
  output logic         o_done,
  output logic         o_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Last prescaler value before the wrap; the prescaler never reaches M.
  localparam logic [N-1:0] PRESC_LAST = N'(M - 1);

  logic [0:0]   r_state;
  logic [N-1:0] r_presc;
  logic [W-1:0] r_count;
  logic         r_mode;
  logic [W-1:0] r_period;
  logic         r_done;
  logic         r_err;

  logic         w_run;
  logic         w_tick;
  logic         w_last_tick;

  assign w_run       = (r_state == S_RUN);
  assign w_tick      = w_run && (r_presc == PRESC_LAST);
  // Count is never 0 while running, so "== 1" marks the final tick.
  assign w_last_tick = w_tick && (r_count == W'(1));

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_count  <= '0;
      r_mode   <= 1'b0;
      r_period <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // Both flags are single-cycle pulses by default.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_count <= '0;
          // stop suppresses both the launch and the error pulse.
          if (i_start && !i_stop) begin
            if (i_period != '0) begin
              r_state  <= S_RUN;
              r_count  <= i_period;
              r_mode   <= i_mode;
              r_period <= i_period;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (i_stop) begin
            // Abort takes precedence over a coincident final tick.
            r_state <= S_IDLE;
            r_presc <= '0;
            r_count <= '0;
          end else begin
            r_presc <= w_tick ? '0 : (r_presc + N'(1));
            if (w_last_tick) begin
              r_done <= 1'b1;
              if (r_mode) begin
                r_count <= r_period;
              end else begin
                r_state <= S_IDLE;
                r_count <= '0;
              end
            end else if (w_tick) begin
              r_count <= r_count - W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_presc <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign o_busy  = w_run;
  assign o_tick  = w_tick;
  assign o_count = r_count;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_prescale_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prescale_timer_ctrl
//
// Bench for prescale_timer_ctrl with M = 4, W = 8: a constant vector table,
// hand-written corner sequences (full one-shot timing, ignored re-start,
// stop on the final tick, asynchronous reset mid-run) and a randomized phase
// compared against a time-based reference model.
// -----------------------------------------------------------------------------
module tb_prescale_timer_ctrl;

  localparam int M = 4;
  localparam int W = 8;

  logic         clk;
  logic         rstb;
  logic         start;
  logic         stop;
  logic         mode;
  logic [W-1:0] period;
  logic         busy;
  logic         tick;
  logic [W-1:0] count;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  prescale_timer_ctrl #(.M(M), .W(W)) dut (
    .i_clk    (clk),
    .i_rstb   (rstb),
    .i_start  (start),
    .i_stop   (stop),
    .i_mode   (mode),
    .i_period (period),
    .o_busy   (busy),
    .o_tick   (tick),
    .o_count  (count),
    .o_done   (done),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a run is described by the number of cycles t elapsed
  // since launch. Ticks fall on t mod M = M-1, the remaining count follows
  // from how many ticks of the current timer cycle have passed.
  // ---------------------------------------------------------------------------
  bit m_active;
  bit m_mode;
  bit m_done;
  bit m_err;
  int m_t;
  int m_p;

  task automatic model_reset();
    m_active = 0;
    m_mode   = 0;
    m_done   = 0;
    m_err    = 0;
    m_t      = 0;
    m_p      = 0;
  endtask

  task automatic model_step(input bit s, input bit st, input bit md, input int p);
    bit dn;
    bit er;
    dn = 0;
    er = 0;
    if (!m_active) begin
      if (s && !st) begin
        if (p != 0) begin
          m_active = 1;
          m_t      = 0;
          m_p      = p;
          m_mode   = md;
        end else begin
          er = 1;
        end
      end
    end else if (st) begin
      m_active = 0;
    end else begin
      if ((m_t % (m_p * M)) == (m_p * M - 1)) begin
        dn = 1;
        if (!m_mode) m_active = 0;
      end
      m_t++;
    end
    m_done = dn;
    m_err  = er;
  endtask

  function automatic int exp_tick();
    return (m_active && ((m_t % M) == M - 1)) ? 1 : 0;
  endfunction

  function automatic int exp_count();
    return m_active ? (m_p - (m_t % (m_p * M)) / M) : 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs stay stable across the edge, the model sees the same
  // values, outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (!rstb) model_reset();
    else model_step(start, stop, mode, int'(period));
    #1;
  endtask

  task automatic idle_inputs();
    start  = 0;
    stop   = 0;
    mode   = 0;
    period = '0;
  endtask

  task automatic do_reset();
    rstb = 0;
    idle_inputs();
    model_reset();
    step();
    step();
    rstb = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied before an edge, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         v_start;
    logic         v_stop;
    logic         v_mode;
    logic [W-1:0] v_period;
    logic         e_busy;
    logic         e_tick;
    logic [W-1:0] e_count;
    logic         e_done;
    logic         e_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  // One-shot period 3, optionally re-pulsing start (period 5, periodic) in
  // the middle of the run; the run must keep its original schedule.
  task automatic run_oneshot3(input bit repulse, input string tag);
    int busy_cycles;
    int tick_mask;
    int done_at;
    int exp_c;
    busy_cycles = 0;
    tick_mask   = 0;
    done_at     = 0;
    start  = 1;
    mode   = 0;
    period = 8'd3;
    step();
    idle_inputs();
    for (int c = 1; c <= 15; c++) begin
      if (busy) busy_cycles++;
      if (tick) tick_mask |= (1 << c);
      if (done) done_at = c;
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        exp_c = (c <= 12) ? (3 - (c - 1) / 4) : 0;
        chk($sformatf("%s_count_c%0d", tag, c), int'(count), exp_c);
      end
      chk($sformatf("%s_err_c%0d", tag, c), int'(err), 0);
      if (repulse && c == 6) begin
        start  = 1;
        mode   = 1;
        period = 8'd5;
      end else begin
        idle_inputs();
      end
      step();
    end
    chk({tag, "_busy_cycles"}, busy_cycles, 12);
    chk({tag, "_tick_mask"}, tick_mask, (1 << 4) | (1 << 8) | (1 << 12));
    chk({tag, "_done_cycle"}, done_at, 13);
  endtask

  initial begin
    rstb = 0;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_busy_async", int'(busy), 0);
    step();
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    rstb = 1;

    // start, stop, mode, period | busy, tick, count, done, err
    vec[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1}; // period 0 -> err
    vec[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}; // err single cycle
    vec[2]  = '{1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}; // stop beats start
    vec[3]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0}; // one-shot P=1
    vec[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0}; // final tick
    vec[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}; // done, idle
    vec[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0}; // periodic P=2
    vec[10] = '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0}; // ignored restart
    vec[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    vec[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
    vec[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0}; // reload, still run
    vec[18] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}; // stop -> idle

    for (int i = 0; i < NV; i++) begin
      start  = vec[i].v_start;
      stop   = vec[i].v_stop;
      mode   = vec[i].v_mode;
      period = vec[i].v_period;
      step();
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vec[i].e_busy));
      chk($sformatf("vec%0d_tick", i), int'(tick), int'(vec[i].e_tick));
      chk($sformatf("vec%0d_count", i), int'(count), int'(vec[i].e_count));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vec[i].e_done));
      chk($sformatf("vec%0d_err", i), int'(err), int'(vec[i].e_err));
      $display("vec %0d: start=%0d stop=%0d mode=%0d period=%0d -> busy=%0d tick=%0d count=%0d done=%0d err=%0d",
               i, vec[i].v_start, vec[i].v_stop, vec[i].v_mode, vec[i].v_period,
               busy, tick, count, done, err);
    end
    idle_inputs();
    step();

    // Full one-shot schedule, then the same with a mid-run start pulse.
    do_reset();
    run_oneshot3(1'b0, "oneshot");
    $display("seq oneshot P=3 complete");
    run_oneshot3(1'b1, "repulse");
    $display("seq oneshot P=3 with ignored restart complete");

    // Stop coincident with the final tick of a one-shot P=1 run.
    do_reset();
    start  = 1;
    period = 8'd1;
    step();
    idle_inputs();
    step();
    step();
    step();
    chk("stoptick_tick", int'(tick), 1);
    stop = 1;
    step();
    stop = 0;
    chk("stoptick_busy", int'(busy), 0);
    chk("stoptick_done", int'(done), 0);
    chk("stoptick_count", int'(count), 0);
    step();
    chk("stoptick_done_late", int'(done), 0);
    $display("seq stop on final tick complete");

    // Asynchronous reset in the middle of a periodic run, on a tick cycle.
    start  = 1;
    mode   = 1;
    period = 8'd2;
    step();
    idle_inputs();
    step();
    step();
    step();
    chk("arst_pre_busy", int'(busy), 1);
    chk("arst_pre_tick", int'(tick), 1);
    #2;
    rstb = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_err", int'(err), 0);
    model_reset();
    step();
    rstb = 1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (done || busy) seen++;
      end
      chk("arst_quiet_after_release", seen, 0);
    end
    $display("seq async reset mid-run complete");

    // Randomized phase against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      mode   = 1'($urandom_range(0, 1));
      period = 8'($urandom_range(0, 5));
      step();
      chk($sformatf("rnd%0d_busy", i), int'(busy), int'(m_active));
      chk($sformatf("rnd%0d_tick", i), int'(tick), exp_tick());
      chk($sformatf("rnd%0d_count", i), int'(count), exp_count());
      chk($sformatf("rnd%0d_done", i), int'(done), int'(m_done));
      chk($sformatf("rnd%0d_err", i), int'(err), int'(m_err));
      if (done && err) begin
        errors++;
        $display("FAIL rnd%0d_done_err_overlap: got both high required exclusive", i);
      end
    end
    $display("random phase: 3000 cycles compared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescale_timer_ctrl.md
PRESCALE_TIMER_CTRL -- requirements
Module: prescale_timer_ctrl

Interface
REQ-001 Parameter M, default 10: prescaler modulus, clk cycles per prescaled tick, M >= 2.
REQ-002 Parameter W, default 8: width of period and count.
REQ-003 Parameter N, default $clog2(M): prescaler register width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstb  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to launch timer; sampled each rising edge.
REQ-007 stop  input  1  request to abort running timer; sampled each rising edge.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic; latched with start.
REQ-009 period  input  W  number of prescaled ticks per timer cycle; latched with start.
REQ-010 busy  output  1  high while in RUN.
REQ-011 tick  output  1  prescaled tick, combinational: RUN and prescaler == M-1.
REQ-012 count  output  W  remaining prescaled ticks in current timer cycle.
REQ-013 done  output  1  registered one-cycle pulse at end of each timer cycle.
REQ-014 err  output  1  registered one-cycle pulse on rejected start.

Function
REQ-015 FSM SHALL have two states: IDLE and RUN; encoding is free.
REQ-016 IDLE SHALL hold prescaler = 0, count = 0, busy = 0.
REQ-017 IDLE, start = 1, stop = 0, period != 0 -> next cycle: RUN, count = period, prescaler = 0; mode and period latched.
REQ-018 IDLE, start = 1, stop = 0, period == 0 -> stay IDLE; err = 1 for exactly the next cycle.
REQ-019 IDLE, start = 1, stop = 1 -> stop wins: stay IDLE, no err.
REQ-020 RUN: prescaler increments by 1 per cycle; at M-1 it wraps to 0 and tick = 1 that cycle.
REQ-021 RUN, tick = 1 and count > 1 -> count decrements by 1.
REQ-022 RUN, tick = 1 and count == 1 -> done = 1 for the next cycle only.
REQ-023 When REQ-022 applies in one-shot mode, next state SHALL be IDLE with count = 0.
REQ-024 When REQ-022 applies in periodic mode, count SHALL reload the latched period, the state SHALL stay RUN, and the prescaler SHALL wrap with no gap.
REQ-025 Latency: with start sampled at edge k, the final tick SHALL occur in the cycle following edge k+P*M-1 (P = latched period), and done SHALL be high in the following cycle.
REQ-026 RUN, stop = 1 -> IDLE next cycle, no done; stop overrides a coincident final tick.
REQ-027 RUN, start = 1 SHALL be ignored: no restart, no re-latch, no err.
REQ-028 Changes to period or mode during RUN SHALL NOT affect the current run.
REQ-029 done and err SHALL never be high in the same cycle; each is a single-cycle pulse.
REQ-030 Prescaler arithmetic SHALL be N bits wide and never reach M; count arithmetic SHALL be W bits wide and never underflow.

Reset
REQ-031 rstb low SHALL immediately force IDLE, prescaler = 0, count = 0, busy = 0, done = 0, err = 0, tick = 0, latched mode = 0, latched period = 0.
REQ-032 Reset asserted mid-RUN SHALL abort with no done; after release the block SHALL wait in IDLE for a new start.

Verification (M = 4, W = 8)
REQ-033 One-shot, period = 3, start pulse -> busy 12 cycles; tick in run cycles 4, 8, 12; count 3 -> 2 -> 1; done one cycle, then busy = 0.
REQ-034 Periodic, period = 2, run 20 cycles -> done every 8 cycles; count reloads to 2; busy stays 1.
REQ-035 start with period = 0 -> err one cycle, busy stays 0, count = 0.
REQ-036 stop asserted in the same cycle as the final tick (one-shot, period = 1) -> IDLE, no done pulse.
REQ-037 start re-pulsed mid-run with period = 5 -> ignored; original period = 3 run completes on schedule.
REQ-038 rstb pulsed low mid-run in periodic mode -> all outputs 0 asynchronously; no done after release until a new start.
